// File: rtl/gc_x360_report_if.sv
// Bus between the GameCube poll decoder and the USB report consumer.
// Carries the decoded frame strobe in and the 20-byte report, send pulse and link status out.
interface gc_x360_report_if;
    logic [63:0]  gc_data;
    logic         gc_valid;
    logic         gc_err;
    logic [159:0] key_value;
    logic         key_request;
    logic         connected;

    modport master (
        output gc_data, gc_valid, gc_err,
        input  key_value, key_request, connected
    );

    modport slave (
        input  gc_data, gc_valid, gc_err,
        output key_value, key_request, connected
    );
endinterface

// File: rtl/gc_x360_report.sv
// GC poll frame -> calibrated Xbox 360 report; report at T+2, earliest key_request at T+3.
// No backpressure: frames are never stalled, sends are rate limited and only the latest report goes out.
module gc_x360_report #(
    parameter int HOLDOFF   = 60000,
    parameter int KEEPALIVE = 8,
    parameter int TIMEOUT   = 6000000,
    parameter int DEADZONE  = 12,
    parameter int GAIN      = 320
) (
    input  logic            clk,
    input  logic            usb_rstn,
    gc_x360_report_if.slave bus
);

    localparam int HW = $clog2(HOLDOFF);
    localparam int TW = $clog2(TIMEOUT);
    localparam int KW = $clog2(KEEPALIVE + 1);

    localparam logic [159:0]       NEUTRAL = {16'h0014, 144'd0};
    localparam logic signed [19:0] GAIN_S  = 20'(GAIN);
    localparam logic signed [19:0] P_MAX   = 20'sd32767;
    localparam logic signed [19:0] P_MIN   = -20'sd32768;
    localparam logic signed [8:0]  DZ_S    = 9'(DEADZONE);

    typedef enum logic {CAL, RUN}   cal_state_t;
    typedef enum logic {IDLE, HOLD} snd_state_t;

    cal_state_t r_cal_state, w_cal_next;
    snd_state_t r_snd_state, w_snd_next;

    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_ctr [4];

    logic          r_s1_vld;
    logic [4:0]    r_s1_b0;
    logic [4:0]    r_s1_b1;
    logic [7:0]    r_s1_la;
    logic [7:0]    r_s1_ra;
    logic signed [8:0] r_s1_d [4];
    logic [3:0]    r_s1_dz;

    logic [159:0]  r_report;
    logic          r_conn;
    logic [159:0]  r_last;
    logic [HW-1:0] r_hold_cnt;
    logic [KW-1:0] r_ka_cnt;
    logic          r_key_request;

    logic          w_acc;
    logic          w_timeout;
    logic [7:0]    w_raw [4];
    logic [7:0]    w_ctr [4];
    logic signed [8:0]  w_d [4];
    logic [3:0]    w_dz;
    logic signed [19:0] w_prod [4];
    logic [15:0]   w_ax [4];
    logic [159:0]  w_report;
    logic          w_send;
    logic          w_wrap;
    logic          w_unused;

    assign w_acc    = bus.gc_valid & ~bus.gc_err;
    assign w_unused = ^{bus.gc_data[63:61], bus.gc_data[55:53]};

    // Stick order: JoyX, JoyY, CX, CY -> LX, LY, RX, RY
    always_comb begin
        w_raw[0] = bus.gc_data[47:40];
        w_raw[1] = bus.gc_data[39:32];
        w_raw[2] = bus.gc_data[31:24];
        w_raw[3] = bus.gc_data[23:16];
    end

    always_comb begin
        w_cal_next = r_cal_state;
        w_timeout  = 1'b0;
        case (r_cal_state)
            CAL: if (w_acc) w_cal_next = RUN;
            RUN: begin
                if (!w_acc && r_to_cnt == TW'(TIMEOUT - 1)) begin
                    w_cal_next = CAL;
                    w_timeout  = 1'b1;
                end
            end
            default: w_cal_next = CAL;
        endcase
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            r_cal_state <= CAL;
            r_to_cnt    <= '0;
            for (int i = 0; i < 4; i++) r_ctr[i] <= '0;
        end else begin
            r_cal_state <= w_cal_next;
            if (w_acc || w_timeout || r_cal_state == CAL)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);
            if (w_acc && r_cal_state == CAL)
                for (int i = 0; i < 4; i++) r_ctr[i] <= w_raw[i];
        end
    end

    // The calibration frame is measured against itself, so its sticks read as centred
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_ctr[i] = (r_cal_state == CAL) ? w_raw[i] : r_ctr[i];
            w_d[i]   = $signed({1'b0, w_raw[i]} - {1'b0, w_ctr[i]});
            w_dz[i]  = (w_d[i] <= DZ_S) && (w_d[i] >= -DZ_S);
        end
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            r_s1_vld <= 1'b0;
            r_s1_b0  <= '0;
            r_s1_b1  <= '0;
            r_s1_la  <= '0;
            r_s1_ra  <= '0;
            r_s1_dz  <= '0;
            for (int i = 0; i < 4; i++) r_s1_d[i] <= '0;
        end else begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_b0 <= bus.gc_data[60:56];
                r_s1_b1 <= bus.gc_data[52:48];
                r_s1_la <= bus.gc_data[15:8];
                r_s1_ra <= bus.gc_data[7:0];
                r_s1_dz <= w_dz;
                for (int i = 0; i < 4; i++) r_s1_d[i] <= w_d[i];
            end
        end
    end

    // 9-bit delta times 10-bit gain cannot overflow 20 bits, so clamping the product is exact
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_ax[i]   = '0;
            w_prod[i] = 20'(r_s1_d[i]) * GAIN_S;
            if (r_s1_dz[i])
                w_ax[i] = '0;
            else if (w_prod[i] > P_MAX)
                w_ax[i] = 16'h7FFF;
            else if (w_prod[i] < P_MIN)
                w_ax[i] = 16'h8000;
            else
                w_ax[i] = w_prod[i][15:0];
        end
    end

    assign w_report = {
        8'h00, 8'h14,
        3'b000, r_s1_b0[4], r_s1_b1[1], r_s1_b1[0], r_s1_b1[2], r_s1_b1[3],
        r_s1_b0[3:0], 2'b00, r_s1_b1[4], 1'b0,
        r_s1_la, r_s1_ra,
        w_ax[0][7:0], w_ax[0][15:8],
        w_ax[1][7:0], w_ax[1][15:8],
        w_ax[2][7:0], w_ax[2][15:8],
        w_ax[3][7:0], w_ax[3][15:8],
        48'd0
    };

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            r_report <= NEUTRAL;
            r_conn   <= 1'b0;
        end else if (w_timeout) begin
            r_report <= NEUTRAL;
            r_conn   <= 1'b0;
        end else if (r_s1_vld) begin
            r_report <= w_report;
            r_conn   <= 1'b1;
        end
    end

    // The holdoff timer keeps wrapping while idle so keepalive periods accrue without sends
    always_comb begin
        w_snd_next = r_snd_state;
        w_send     = 1'b0;
        w_wrap     = (r_hold_cnt == HW'(HOLDOFF - 1));
        case (r_snd_state)
            IDLE: begin
                if (r_report != r_last || r_ka_cnt == KW'(KEEPALIVE)) begin
                    w_send     = 1'b1;
                    w_snd_next = HOLD;
                end
            end
            HOLD: if (w_wrap) w_snd_next = IDLE;
            default: w_snd_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            r_snd_state   <= IDLE;
            r_last        <= NEUTRAL;
            r_hold_cnt    <= '0;
            r_ka_cnt      <= '0;
            r_key_request <= 1'b0;
        end else begin
            r_snd_state   <= w_snd_next;
            r_key_request <= w_send;
            if (w_send) begin
                r_last     <= r_report;
                r_hold_cnt <= '0;
                r_ka_cnt   <= '0;
            end else begin
                r_hold_cnt <= w_wrap ? '0 : r_hold_cnt + HW'(1);
                if (w_wrap && r_ka_cnt != KW'(KEEPALIVE))
                    r_ka_cnt <= r_ka_cnt + KW'(1);
            end
        end
    end

    assign bus.key_value   = r_report;
    assign bus.key_request = r_key_request;
    assign bus.connected   = r_conn;

endmodule

// File: tb/tb_gc_x360_report.sv
// Randomized and directed bench for gc_x360_report against a cycle-level behavioural model.
module tb_gc_x360_report;
    localparam int H  = 40;
    localparam int K  = 8;
    localparam int TO = 600;
    localparam int DZ = 12;
    localparam int G  = 320;
    localparam logic [159:0] NEUTRAL = {16'h0014, 144'd0};
    localparam logic [63:0]  CAL0    = 64'h0080_8080_8080_0000;

    logic clk = 1'b0;
    logic usb_rstn = 1'b1;
    gc_x360_report_if bus();

    gc_x360_report #(
        .HOLDOFF(H), .KEEPALIVE(K), .TIMEOUT(TO), .DEADZONE(DZ), .GAIN(G)
    ) dut (
        .clk(clk),
        .usb_rstn(usb_rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int           t;
        logic [159:0] r;
    } pend_t;

    bit           m_cal;
    bit           m_conn;
    bit           m_sent;
    bit           m_req;
    logic [7:0]   m_ctr [4];
    int           m_last_acc;
    int           m_sent_cyc;
    logic [159:0] m_cur, m_prev, m_last_sent;
    pend_t        m_q[$];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] axis(input logic [7:0] raw, input logic [7:0] c);
        int d, p;
        d = int'(raw) - int'(c);
        if (d <= DZ && d >= -DZ) return 16'h0000;
        p = d * G;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    function automatic logic [159:0] mk_report(input logic [63:0] d);
        logic [7:0]   b [20];
        logic [7:0]   g0, g1;
        logic [15:0]  v;
        logic [159:0] r;
        for (int k = 0; k < 20; k++) b[k] = 8'h00;
        b[1] = 8'h14;
        g0 = d[63:56];
        g1 = d[55:48];
        b[2] = {3'b000, g0[4], g1[1], g1[0], g1[2], g1[3]};
        b[3] = {g0[3:0], 2'b00, g1[4], 1'b0};
        b[4] = d[15:8];
        b[5] = d[7:0];
        for (int i = 0; i < 4; i++) begin
            v = axis(d[47-8*i -: 8], m_ctr[i]);
            b[6+2*i] = v[7:0];
            b[7+2*i] = v[15:8];
        end
        r = '0;
        for (int k = 0; k < 20; k++) r[159-8*k -: 8] = b[k];
        return r;
    endfunction

    task automatic model_reset();
        m_cal       = 1'b1;
        m_conn      = 1'b0;
        m_cur       = NEUTRAL;
        m_prev      = NEUTRAL;
        m_last_sent = NEUTRAL;
        m_sent      = 1'b0;
        m_sent_cyc  = cyc;
        m_last_acc  = 0;
        m_q.delete();
    endtask

    task automatic model_accept(input logic [63:0] d);
        pend_t e;
        if (m_cal) begin
            for (int i = 0; i < 4; i++) m_ctr[i] = d[47-8*i -: 8];
            m_cal = 1'b0;
        end
        m_last_acc = cyc;
        e.t = cyc + 2;
        e.r = mk_report(d);
        m_q.push_back(e);
    endtask

    // One clock: compare this cycle's outputs with the model, then drive this cycle's inputs
    task automatic step(input logic v, input logic e, input logic [63:0] d);
        @(negedge clk);
        cyc++;
        while (m_q.size() > 0 && m_q[0].t == cyc) begin
            m_cur  = m_q[0].r;
            m_conn = 1'b1;
            void'(m_q.pop_front());
        end
        if (!m_cal && cyc == m_last_acc + TO + 1) begin
            m_cal  = 1'b1;
            m_cur  = NEUTRAL;
            m_conn = 1'b0;
        end
        m_req = 1'b0;
        if ((!m_sent || cyc - 1 >= m_sent_cyc + H) &&
            (m_prev != m_last_sent || cyc - 1 >= m_sent_cyc + K * H)) begin
            m_req       = 1'b1;
            m_last_sent = m_prev;
            m_sent_cyc  = cyc;
            m_sent      = 1'b1;
        end
        check("key_request", bus.key_request, m_req);
        check("connected", bus.connected, m_conn);
        check("key_value", bus.key_value, m_cur);
        m_prev = m_cur;
        bus.gc_valid = v;
        bus.gc_err   = e;
        bus.gc_data  = d;
        if (v && !e) model_accept(d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 64'h0);
    endtask

    task automatic frame(input logic [63:0] d);
        step(1'b1, 1'b0, d);
    endtask

    // Call only after an idle step so no frame is in flight at the reset edge
    task automatic do_reset();
        bus.gc_valid = 1'b0;
        bus.gc_err   = 1'b0;
        #2 usb_rstn = 1'b0;
        #1;
        check("rst_key_request", bus.key_request, 1'b0);
        check("rst_connected", bus.connected, 1'b0);
        check("rst_key_value", bus.key_value, NEUTRAL);
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        usb_rstn = 1'b1;
        model_reset();
    endtask

    function automatic logic [63:0] rnd_frame();
        logic [63:0] f;
        logic [31:0] r;
        int          v;
        r = $urandom;
        f = '0;
        f[63:56] = {3'b000, r[4:0]};
        f[55:48] = {1'b1, r[11:5]};
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 113 + int'($urandom_range(0, 30));
                1:       v = int'($urandom_range(0, 255));
                2:       v = ($urandom_range(0, 1) == 1) ? 255 : 0;
                default: v = 128;
            endcase
            f[47-8*i -: 8] = 8'(v);
        end
        f[15:0] = 16'($urandom);
        return f;
    endfunction

    logic [159:0] kv;
    int           sel;

    initial begin
        bus.gc_valid = 1'b0;
        bus.gc_err   = 1'b0;
        bus.gc_data  = '0;
        do_reset();

        // calibration frame leaves the report neutral, so nothing is sent
        idle(5);
        frame(CAL0);
        idle(2);
        check("cal_connected", bus.connected, 1'b1);
        check("cal_neutral", bus.key_value, NEUTRAL);
        idle(1);
        check("cal_no_request", bus.key_request, 1'b0);

        idle(50);
        frame(64'h0080_FF80_8080_0000);
        idle(2);
        kv = bus.key_value;
        check("sat_pos_lx", kv[111:96], 16'hFF7F);
        idle(1);
        check("sat_pos_pulse", bus.key_request, 1'b1);

        idle(50);
        frame(64'h0080_0080_8080_0000);
        idle(2);
        kv = bus.key_value;
        check("sat_neg_lx", kv[111:96], 16'h0080);

        idle(50);
        frame(64'h0080_808C_8080_0000);
        idle(2);
        kv = bus.key_value;
        check("dz_edge_ly", kv[95:80], 16'h0000);

        idle(50);
        frame(64'h0080_808D_8080_0000);
        idle(2);
        kv = bus.key_value;
        check("dz_out_ly", kv[95:80], 16'h4010);

        idle(50);
        frame(64'h0188_8080_8080_0000);
        idle(2);
        kv = bus.key_value;
        check("a_up_bytes23", kv[143:128], 16'h0110);

        // two differing frames inside one holdoff window
        idle(50);
        frame(64'h0080_A080_8080_0000);
        idle(3);
        check("rate_first", bus.key_request, 1'b1);
        idle(6);
        frame(64'h0080_6080_8080_0000);
        idle(33);
        check("rate_hold", bus.key_request, 1'b0);
        idle(1);
        check("rate_second", bus.key_request, 1'b1);
        kv = bus.key_value;
        check("rate_second_lx", kv[111:96], 16'h00D8);

        // unchanged report: keepalive resends only
        idle(9 * H + 20);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 6)       step(1'b1, 1'b0, rnd_frame());
            else if (sel < 8)  step(1'b1, 1'b1, rnd_frame());
            else if (sel < 10) begin
                repeat (4) step(1'b1, 1'b0, rnd_frame());
            end
            else               idle(1);
        end

        // only errored frames: controller must time out
        for (int n = 0; n < TO + 100; n++)
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'b1, rnd_frame());
        check("timeout_connected", bus.connected, 1'b0);
        check("timeout_neutral", bus.key_value, NEUTRAL);

        // reset in the middle of a holdoff window
        frame(CAL0);
        idle(50);
        frame(64'h0080_FF80_8080_0000);
        idle(3);
        check("pre_rst_pulse", bus.key_request, 1'b1);
        idle(5);
        do_reset();
        idle(3);
        frame(CAL0);
        idle(5);
        frame(64'h0080_FF80_8080_0000);
        idle(3);
        check("post_rst_pulse", bus.key_request, 1'b1);
        idle(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gc_x360_report.md
# gc_x360_report

Formatter stage that sits directly upstream of the USB full-speed controller top. It takes decoded 64-bit GameCube poll responses, applies per-stick centre calibration, deadzone and gain with saturation, and assembles the 20-byte Xbox 360 input report on `key_value`. It issues single-cycle `key_request` pulses at a rate-limited cadence: on any report change, or as a periodic keepalive.

## Interface
- `HOLDOFF`, 60000: minimum clk cycles between `key_request` pulses (1 ms at 60 MHz); must be ≥ 32.
- `KEEPALIVE`, 8: unchanged report is resent after this many holdoff periods.
- `TIMEOUT`, 6000000: clk cycles without an accepted frame before controller is declared lost (100 ms).
- `DEADZONE`, 12: absolute stick delta (raw units) treated as zero.
- `GAIN`, 320: unsigned 10-bit multiplier, stick delta to int16.
- `clk` input 1: 60 MHz system clock.
- `usb_rstn` input 1: asynchronous, active-low reset.
- `gc_data` input 64: poll response. Byte0 = {3'b0,Start,Y,X,B,A}; byte1 = {1,L,R,Z,Up,Down,Right,Left}; bytes 2–7 = JoyX, JoyY, CX, CY, Lanalog, Ranalog. Byte0 is `gc_data[63:56]`.
- `gc_valid` input 1: one-cycle strobe, `gc_data` valid.
- `gc_err` input 1: qualifies `gc_valid`. A frame is ignored if `gc_err`=1 in the same cycle.
- `key_value` output 160: report. Byte k = `key_value[159-8k -: 8]`, byte0 sent first.
- `key_request` output 1: one-cycle send pulse.
- `connected` output 1: 1 while controller is calibrated and not timed out.

## Operation
- **Report layout:**
  - byte0 = 0x00; byte1 = 0x14.
  - byte2 = {0,0,0,0,Right,Left,Down,Up}. Bits 4–7 (Start/Back/LS/RS) stay 0, except bit4 = Start.
  - byte3 = {Y,X,B,A,0,0,RB=Z,LB=0}.
  - byte4 = Lanalog; byte5 = Ranalog.
  - bytes 6–7 = LX, 8–9 = LY, 10–11 = RX, 12–13 = RY. Each is int16 little-endian (low byte first).
  - bytes 14–19 = 0.
- **Calibration state machine (CAL → RUN → CAL):**
  - CAL: report is neutral (bytes 0–1 constant, all else 0). The first accepted frame latches JoyX, JoyY, CX, CY as the four centres, then moves to RUN and processes that same frame.
  - RUN: every accepted frame updates the report.
  - TIMEOUT cycles with no accepted frame → CAL. Report forced neutral, `connected`=0.
- **Axis arithmetic:**
  - d = {1'b0,raw} − {1'b0,centre}, 9-bit signed.
  - If |d| ≤ DEADZONE, out = 0.
  - Otherwise p = d × GAIN, 19-bit signed, saturated to [−32768, 32767].
  - No axis inversion: GC up (larger raw) maps to positive.
- **Triggers:** passed through unchanged.
- **Send state machine (IDLE, HOLD):**
  - IDLE: pulse `key_request` when the report register differs from the last-sent copy, or the keepalive count reaches KEEPALIVE. In that same cycle, copy the report to last-sent and go to HOLD.
  - HOLD: count HOLDOFF cycles, then return to IDLE. Each HOLD completion with no send increments the keepalive count, saturating; any send clears it.
- **Stability:** `key_value` changes only on report-register updates. The downstream block captures `key_value` in the `key_request` cycle, so later changes are harmless.
- **Simultaneous timeout and accepted frame:** the frame wins; the timeout counter clears.
- **Simultaneous CAL→neutral change and send eligibility:** the neutral report is sent as a normal change.

## Timing
- **Reset values:**
  - `key_request`=0, `connected`=0.
  - `key_value` = 0x0014 followed by 144 zero bits (neutral).
  - State CAL/IDLE; all counters 0; last-sent = neutral; keepalive count 0.
- **Pipeline:** frame accepted at cycle T.
  - T+1: register deltas and deadzone flags.
  - T+2: saturated values into the report register; `connected`=1 if this was the calibration frame.
  - Earliest `key_request` at T+3, if IDLE.
- **HOLD timing:** a `key_request` at cycle S forbids another before S+HOLDOFF+1.
- **Frame handling:** frames arriving during HOLD still update the report. Only the latest report at HOLD exit is compared and sent; intermediate values are dropped.
- **Timeout counter:** increments every cycle in RUN, clears on an accepted frame. Reaching TIMEOUT−1 forces CAL on the next edge.
- **Reset mid-operation:** asynchronous `usb_rstn` low returns every register to its reset value immediately. No partial pulse may be emitted.

## Test plan
- **Reset and first frame:** `usb_rstn` deasserted, `gc_data`=0x0080_8080_8080_0000 accepted → `key_value` bytes 0–1 = 00 14, rest 0; `connected`=1 at T+2; no `key_request`, because the report is unchanged vs last-sent.
- **Saturation and little-endian order:** after calibration at 0x80, JoyX=0xFF → d=127, p=40640 → bytes 6–7 = FF 7F, `key_request` at T+3. JoyX=0x00 → bytes 6–7 = 00 80.
- **Deadzone and buttons:** JoyY=0x8C (d=12) → bytes 8–9 = 00 00. JoyY=0x8D (d=13) → 4160 = 40 10. A + Up pressed → byte3 bit4 = 1, byte2 bit0 = 1.
- **Rate limiting:** two differing frames 100 cycles apart → exactly one pulse at T+3, then a second pulse exactly HOLDOFF+1 cycles after the first, carrying the second frame.
- **Keepalive and timeout:** no change for 9 holdoff periods → a resend pulse every KEEPALIVE periods. Stop `gc_valid` for TIMEOUT cycles → `connected`=0, neutral report sent; a frame with `gc_err`=1 is ignored and does not reset the timer.
- **Reset mid-HOLD:** assert `usb_rstn` low during HOLD → all outputs return to reset values at once; after release, the first differing frame is sent at T+3.
